// File: rtl/cnn_pkg.sv
// Shared CNN dimensions and widths so the convolution and pooling stages agree.
package cnn_pkg;

    localparam int unsigned CNN_IMG    = 32;  // input image side, pixels
    localparam int unsigned CNN_K      = 5;   // convolution kernel side
    localparam int unsigned CNN_BW1    = 8;   // pixel width
    localparam int unsigned CNN_BW2    = 8;   // weight width
    localparam int unsigned CNN_BW     = 16;  // convolution output sample width
    localparam int unsigned CNN_NMAPS  = 6;   // weight sets / feature maps

    localparam int unsigned CNN_CONV_W = CNN_IMG - CNN_K + 1;
    localparam int unsigned CNN_CONV_H = CNN_IMG - CNN_K + 1;
    localparam int unsigned CNN_POOL_W = CNN_CONV_W / 2;
    localparam int unsigned CNN_POOL_H = CNN_CONV_H / 2;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned addr_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relu_maxpool2x2_if.sv
// Sample stream into and pooled stream out of the ReLU + 2x2 max-pool stage.
interface relu_maxpool2x2_if #(
    parameter int unsigned BW = cnn_pkg::CNN_BW
) ();

    logic                 valid;
    logic signed [BW-1:0] x;
    logic                 ovalid;
    logic signed [BW-1:0] y;
    logic                 last;

    modport master (output valid, x, input  ovalid, y, last);
    modport slave  (input  valid, x, output ovalid, y, last);

endinterface

// File: rtl/relu_maxpool2x2_linebuf.sv
// Half-width line buffer holding the horizontal pair maxima of the last even row.
module pool_linebuf
    import cnn_pkg::*;
#(
    parameter int unsigned BW    = CNN_BW,
    parameter int unsigned DEPTH = CNN_POOL_W,
    parameter int unsigned AW    = addr_bits(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic signed [BW-1:0] wdata_i,
    input  logic [AW-1:0]        raddr_i,
    output logic signed [BW-1:0] rdata_o
);

    logic signed [BW-1:0] mem_q [DEPTH];

    // Contents are don't-care after reset: each entry is rewritten on every even row.
    always_ff @(posedge clk_i) begin
        if (we_i && (32'(waddr_i) < DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (32'(raddr_i) < DEPTH) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/relu_maxpool2x2.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-order conv output stream.
module relu_maxpool2x2
    import cnn_pkg::*;
#(
    parameter int unsigned BW = CNN_BW,
    parameter int unsigned W  = CNN_CONV_W,
    parameter int unsigned H  = CNN_CONV_H
) (
    input  logic                 iCLK,
    input  logic                 iRSTn,
    input  logic                 iValid,
    input  logic signed [BW-1:0] iX,
    output logic                 oValid,
    output logic signed [BW-1:0] oY,
    output logic                 oLast
);

    localparam int unsigned CW = addr_bits(W);
    localparam int unsigned RW = addr_bits(H);
    localparam int unsigned AW = addr_bits(W / 2);

    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic signed [BW-1:0] hold_q, hold_d;
    logic signed [BW-1:0] y_q, y_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;

    logic signed [BW-1:0] pm;
    logic signed [BW-1:0] lb_rd;
    logic signed [BW-1:0] m4;
    logic signed [BW-1:0] relu;
    logic                 lb_we;
    logic [AW-1:0]        lb_addr;
    logic                 col_odd;
    logic                 row_odd;
    logic                 fire;
    logic                 end_of_row;

    pool_linebuf #(
        .BW    (BW),
        .DEPTH (W / 2),
        .AW    (AW)
    ) u_linebuf (
        .clk_i   (iCLK),
        .we_i    (lb_we),
        .waddr_i (lb_addr),
        .wdata_i (pm),
        .raddr_i (lb_addr),
        .rdata_o (lb_rd)
    );

    always_comb begin
        col_odd    = col_q[0];
        row_odd    = row_q[0];
        end_of_row = (col_q == COL_LAST);
        lb_addr    = AW'(col_q >> 1);

        pm   = (iX > hold_q) ? iX : hold_q;
        m4   = (lb_rd > pm) ? lb_rd : pm;
        relu = m4[BW-1] ? '0 : m4;

        lb_we = iValid && col_odd && !row_odd;
        fire  = iValid && col_odd && row_odd;
    end

    // Every state change is gated on iValid so idle cycles leave the pipeline frozen.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        hold_d  = hold_q;
        y_d     = y_q;
        valid_d = fire;
        last_d  = fire && end_of_row && (row_q == ROW_LAST);

        if (iValid) begin
            if (!col_odd) begin
                hold_d = iX;
            end
            if (end_of_row) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (fire) begin
            y_d = relu;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            col_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            hold_q  <= hold_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign oValid = valid_q;
    assign oY     = y_q;
    assign oLast  = last_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Scoreboard bench for relu_maxpool2x2: whole-map reference model, decoupled output monitor.
module tb_relu_maxpool2x2;
    import cnn_pkg::*;

    localparam int BW = 16;
    localparam int W  = 28;
    localparam int H  = 28;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    relu_maxpool2x2_if #(.BW(BW)) bus ();

    relu_maxpool2x2 #(.BW(BW), .W(W), .H(H)) dut (
        .iCLK   (clk),
        .iRSTn  (rst_n),
        .iValid (bus.valid),
        .iX     (bus.x),
        .oValid (bus.ovalid),
        .oY     (bus.y),
        .oLast  (bus.last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int y;
        int last;
        int at;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   checks = 0;
    int   img [H][W];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Pooled value of the 2x2 window whose bottom-right sample is (r, c).
    function automatic int pool_ref(input int r, input int c);
        int m;
        m = img[r-1][c-1];
        if (img[r-1][c] > m) m = img[r-1][c];
        if (img[r][c-1] > m) m = img[r][c-1];
        if (img[r][c]   > m) m = img[r][c];
        return (m < 0) ? 0 : m;
    endfunction

    task automatic fill_ramp(input int offset);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = r * W + c + offset;
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = v;
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = int'($urandom_range(65535, 0)) - 32768;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.x     = BW'($urandom);
    endtask

    // Streams the first count samples of img; a window's result is due one cycle after its last sample.
    task automatic stream(input bit gaps, input int count);
        int r, c;
        for (int i = 0; i < count; i++) begin
            r = i / W;
            c = i % W;
            @(posedge clk);
            #1;
            bus.valid = 1'b1;
            bus.x     = BW'(img[r][c]);
            if ((r % 2 == 1) && (c % 2 == 1))
                sb.push_back('{pool_ref(r, c), int'((r == H-1) && (c == W-1)), cyc + 1});
            if (gaps) idle();
        end
    endtask

    task automatic drain();
        repeat (4) idle();
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("reset_oValid", int'(bus.ovalid), 0);
            check("reset_oLast",  int'(bus.last), 0);
            check("reset_oY",     int'($signed(bus.y)), 0);
        end
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ovalid) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got oY=%0d with no expected output", $signed(bus.y));
                end else begin
                    e = sb.pop_front();
                    check("oY",      int'($signed(bus.y)), e.y);
                    check("oLast",   int'(bus.last), e.last);
                    check("latency", cyc, e.at);
                end
            end else if (bus.last) begin
                checks++;
                $display("FAIL oLast_without_oValid: got oLast=1 expected 0");
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pr, pc;
        bus.valid = 1'b1;
        bus.x     = BW'($urandom);
        rst_n     = 1'b0;
        check_reset_outputs(3);
        idle();
        rst_n = 1'b1;

        fill_ramp(0);
        stream(1'b0, W * H);
        drain();

        fill_const(-5);
        stream(1'b0, W * H);
        drain();

        fill_const(-32768);
        pr = int'($urandom_range(H/2 - 1, 0));
        pc = int'($urandom_range(W/2 - 1, 0));
        img[2*pr + int'($urandom_range(1, 0))][2*pc + int'($urandom_range(1, 0))] = 7;
        stream(1'b0, W * H);
        drain();

        fill_ramp(0);
        stream(1'b1, W * H);
        drain();

        for (int m = 0; m < 6; m++) begin
            fill_ramp(1000 * m);
            stream(1'b0, W * H);
        end
        drain();

        for (int m = 0; m < 2; m++) begin
            fill_random();
            stream(1'b0, W * H);
        end
        drain();

        fill_ramp(0);
        stream(1'b0, 300);
        drain();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        bus.valid = 1'b1;
        check_reset_outputs(4);
        idle();
        rst_n = 1'b1;
        fill_ramp(0);
        stream(1'b0, W * H);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/relu_maxpool2x2.md
RELU_MAXPOOL2X2 -- requirements
Module: relu_maxpool2x2

Interface
REQ-001 SHALL have parameter BW, default 16: signed sample width; equals the convolution output width.
REQ-002 SHALL have parameter W, default 28: input feature-map width in samples; even, at least 2.
REQ-003 SHALL have parameter H, default 28: input feature-map height in rows; even, at least 2.
REQ-004 SHALL have port iCLK, input, 1: single clock, rising edge.
REQ-005 SHALL have port iRSTn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port iValid, input, 1: iX carries a valid convolution output this cycle; driven directly by the convolution oValid.
REQ-007 SHALL have port iX, input, BW, signed: convolution output sample, raster order, row-major.
REQ-008 SHALL have port oValid, output, 1: oY is valid this cycle.
REQ-009 SHALL have port oY, output, BW, signed: pooled, rectified sample.
REQ-010 SHALL have port oLast, output, 1: high with the final pooled sample of each map.

Function
REQ-011 SHALL count accepted samples only: column counter col 0..W-1 and row counter row 0..H-1 advance only on iValid=1.
- Idle cycles (iValid=0) inside a row or map SHALL NOT change any state.
REQ-012 SHALL wrap col from W-1 to 0 and increment row; SHALL wrap row from H-1 to 0 at the end of a map, so the next map starts with no idle gap.
REQ-013 SHALL hold the sample in register hold when col is even.
REQ-014 SHALL form pm = signed max(hold, iX) when col is odd.
REQ-015 When row is even and col is odd, SHALL write pm into line buffer entry col>>1; the buffer has W/2 entries of BW bits.
REQ-016 When row is odd and col is odd, SHALL compute m4 = signed max(linebuf[col>>1], pm) and y = (m4 < 0) ? 0 : m4.
REQ-017 SHALL register y onto oY and assert oValid for exactly one cycle, on the clock edge after the accepting edge (latency 1).
REQ-018 SHALL otherwise hold oValid=0; oY SHALL keep its last value while oValid=0.
REQ-019 SHALL assert oLast together with oValid when the output comes from row=H-1, col=W-1; SHALL hold oLast=0 otherwise.
REQ-020 SHALL emit exactly (W/2)*(H/2) outputs per map (196 at defaults), in raster order of the pooled map.
REQ-021 SHALL use signed two's-complement comparisons throughout; no saturation or width change, since the result is a max of inputs.
REQ-022 SHALL NOT require line-buffer contents to be cleared between maps; every entry is written on an even row before it is read on the following odd row.
REQ-023 SHALL have no backpressure; the downstream stage accepts every oValid cycle.

Reset
REQ-024 While iRSTn=0, SHALL force col=0, row=0, oValid=0, oLast=0, oY=0, hold=0.
- Line-buffer contents are don't-care.
REQ-025 Reset asserted mid-map SHALL abandon the partial map; the first iValid after release SHALL be treated as row 0, col 0.

Structure
REQ-026 SHALL take BW, W and H defaults from the shared package cnn_pkg, which also holds the convolution BW1/BW2 and map sizes, so conv and pool stay consistent.
REQ-027 SHALL instantiate one sub-module, pool_linebuf: a W/2 x BW register-array line buffer with write enable, write address, read address and combinational read.
REQ-028 SHALL build the counters, hold register, comparators and output register inline in relu_maxpool2x2.

Verification
REQ-029 Ramp: iX = row*W+col for one 28x28 map, iValid continuous -> 196 outputs; output k (pr=k/14, pc=k%14) = (2pr+1)*28+2pc+1; oLast only on output 195 (value 783).
REQ-030 All negative: every iX=-5 -> 196 outputs all 0.
- iX=-32768 with one 2x2 window containing 7 -> that window outputs 7, all others 0.
REQ-031 Gaps: ramp map with iValid toggled 1,0,1,0... -> same 196 values as REQ-029; each oValid exactly one cycle after its accepting edge.
REQ-032 Back-to-back: 6 maps streamed continuously, map m = ramp + 1000*m -> 1176 outputs, oLast on outputs 195, 391, ..., 1175, values correct per map.
REQ-033 Reset mid-map: pull iRSTn low after 300 samples, then release and stream a full ramp map -> oValid/oLast/oY are 0 during reset; exactly 196 correct outputs afterwards.
REQ-034 Chained: feed the convolution-stage output stream (32x32 input, 6 weight sets) through the block -> matches the 14x14x6 reference pool vector file sample for sample.
